// File: rtl/drum_pkg.sv
// Shared types, saturation limits and the gain/saturate helper for the drum
// mesh audio bridge.
package drum_pkg;

    typedef logic signed [17:0] node_t;
    typedef logic signed [15:0] audio_t;

    localparam node_t NODE_MAX = 18'sh1FFFF;
    localparam node_t NODE_MIN = -18'sh20000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2,
        HOLD  = 2'd3
    } strike_state_t;

    // Shift into a 22-bit headroom word (shift <= 4) and clamp to node range.
    function automatic node_t sat_gain(input node_t n, input int unsigned sh);
        logic signed [21:0] wide;
        wide = {{4{n[17]}}, n};
        wide = wide <<< sh;
        if (wide > 22'sh01FFFF) begin
            return NODE_MAX;
        end else if (wide < -22'sh020000) begin
            return NODE_MIN;
        end else begin
            return node_t'(wide[17:0]);
        end
    endfunction

endpackage

// File: rtl/drum_audio_bridge_if.sv
// Mesh-sample input and audio valid/ready stream of the drum audio bridge.
interface drum_audio_bridge_if;
    import drum_pkg::*;

    node_t  node_in;
    logic   node_valid;
    audio_t audio_data;
    logic   audio_valid;
    logic   audio_ready;

    modport master (
        input  node_in,
        input  node_valid,
        input  audio_ready,
        output audio_data,
        output audio_valid
    );

    modport slave (
        output node_in,
        output node_valid,
        output audio_ready,
        input  audio_data,
        input  audio_valid
    );

endinterface

// File: rtl/drum_sample_fifo.sv
// First-word-fall-through sample FIFO with a registered head output over a
// block-RAM style memory (reads never target the address being written).
module drum_sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    (* ramstyle = "no_rw_check" *) logic [WIDTH-1:0] mem_r [DEPTH];

    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW-1:0]  rd_next_s;
    logic [AW:0]    count_r;
    logic [AW:0]    count_s;
    logic [WIDTH-1:0] dout_r;
    logic           empty_r;
    logic           full_r;
    logic           pop_ok_s;
    logic           push_ok_s;
    logic           bypass_s;

    // Handshake qualification, next read pointer and next occupancy.
    always_comb begin
        pop_ok_s  = pop && !empty_r;
        push_ok_s = push && (!full_r || pop_ok_s);
        rd_next_s = rd_ptr_r + AW'(pop_ok_s);
        // New word becomes the head when the FIFO is empty after this pop.
        bypass_s  = push_ok_s && (count_r == (AW+1)'(pop_ok_s));
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + (AW+1)'(1);
            2'b01:   count_s = count_r - (AW+1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy flags and the registered head word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            dout_r   <= WIDTH'(0);
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
            rd_ptr_r <= rd_next_s;
            count_r  <= count_s;
            empty_r  <= (count_s == (AW+1)'(0));
            full_r   <= (count_s == (AW+1)'(DEPTH));
            if (bypass_s) begin
                dout_r <= din;
            end else if (count_s != (AW+1)'(0)) begin
                dout_r <= mem_r[rd_next_s];
            end
        end
    end

    assign dout  = dout_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;

endmodule

// File: rtl/drum_audio_bridge.sv
// Captures the drum mesh centre node once per timestep, applies saturating gain,
// queues 16-bit audio for the codec stream and generates the mesh strike pulse.
module drum_audio_bridge
    import drum_pkg::*;
#(
    parameter int unsigned DATA_W        = 18,
    parameter int unsigned AUDIO_W       = 16,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned GAIN_SHIFT    = 2,
    parameter int unsigned STRIKE_PERIOD = 48000
) (
    input  logic                clk,
    input  logic                rst,
    drum_audio_bridge_if.master bus,
    input  logic                strike_en,
    input  logic                strike_req,
    output logic                shoot,
    output logic [15:0]         drop_count
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(STRIKE_PERIOD);

    node_t              s1_r;
    logic               s1_valid_r;
    logic [AUDIO_W-1:0] sample_s;
    logic               pop_s;
    logic               accept_s;
    logic               drop_s;
    logic [15:0]        drop_count_r;
    logic [AUDIO_W-1:0] fifo_dout_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [CW-1:0]      fifo_count_s;

    strike_state_t      state_r;
    strike_state_t      state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               shoot_r;

    // Gain stage: one saturated node sample per completed timestep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_r       <= 18'sh00000;
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= bus.node_valid;
            if (bus.node_valid) begin
                s1_r <= sat_gain(bus.node_in, GAIN_SHIFT);
            end
        end
    end

    assign sample_s = s1_r[DATA_W-1 -: AUDIO_W];
    assign pop_s    = !fifo_empty_s && bus.audio_ready;
    // A full FIFO still takes the sample if the sink drains a word this cycle.
    assign accept_s = s1_valid_r && ((fifo_count_s < CW'(FIFO_DEPTH)) || pop_s);
    assign drop_s   = s1_valid_r && fifo_full_s && !pop_s;

    drum_sample_fifo #(
        .WIDTH (AUDIO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .pop   (pop_s),
        .din   (sample_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    // Saturating count of samples lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_count_r <= 16'h0000;
        end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end
    end

    // Strike sequencing: count accepted timesteps or honour a manual request.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_s = CNT_W'(0);
                if (strike_req) begin
                    state_s = FIRE;
                end else if (strike_en) begin
                    state_s = COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (strike_req) begin
                    state_s = FIRE;
                    cnt_s   = CNT_W'(0);
                end else if (bus.node_valid && (cnt_r == CNT_W'(STRIKE_PERIOD - 1))) begin
                    state_s = FIRE;
                    cnt_s   = CNT_W'(0);
                end else if (!strike_en) begin
                    state_s = IDLE;
                    cnt_s   = CNT_W'(0);
                end else if (bus.node_valid) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            FIRE: begin
                state_s = HOLD;
                cnt_s   = CNT_W'(0);
            end
            HOLD: begin
                // The timestep that releases HOLD is the first of the next period.
                if (bus.node_valid) begin
                    if (strike_en) begin
                        state_s = COUNT;
                        cnt_s   = CNT_W'(1);
                    end else begin
                        state_s = IDLE;
                        cnt_s   = CNT_W'(0);
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_W'(0);
            end
        endcase
    end

    // Strike state, period counter and registered shoot pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_W'(0);
            shoot_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shoot_r <= (state_s == FIRE);
        end
    end

    assign bus.audio_data  = audio_t'(fifo_dout_s);
    assign bus.audio_valid = !fifo_empty_s;
    assign shoot           = shoot_r;
    assign drop_count      = drop_count_r;

endmodule

// File: tb/tb_drum_audio_bridge.sv
// Self-checking bench for drum_audio_bridge: directed feature scenarios plus
// randomized traffic against a queue-based reference model.
module tb_drum_audio_bridge;
    import drum_pkg::*;

    localparam int PERIOD = 4;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        strike_en;
    logic        strike_req;
    logic        shoot;
    logic [15:0] drop_count;

    drum_audio_bridge_if bus();

    drum_audio_bridge #(
        .DATA_W(18), .AUDIO_W(16), .FIFO_DEPTH(DEPTH),
        .GAIN_SHIFT(2), .STRIKE_PERIOD(PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .strike_en(strike_en), .strike_req(strike_req),
        .shoot(shoot), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [15:0] exp_q[$];
    bit          m_s1v;
    logic [15:0] m_s1;
    int          m_drop;
    int          m_mode;   // 0 idle, 1 counting, 2 firing, 3 holding
    int          m_cnt;    // timesteps accepted in the current period
    bit          m_shoot;

    function automatic logic [15:0] ref_sample(input int v);
        int g;
        g = v * 4;
        if (g > 131071) g = 131071;
        if (g < -131072) g = -131072;
        return 16'(g >>> 2);
    endfunction

    // Advance the model with the inputs present now, then clock the DUT.
    task automatic step();
        bit pop;
        bit acc;
        bit nv;
        nv = bus.node_valid;
        if (!rst) begin
            exp_q.delete();
            m_s1v = 1'b0; m_drop = 0; m_mode = 0; m_cnt = 0; m_shoot = 1'b0;
        end else begin
            pop = (exp_q.size() > 0) && bus.audio_ready;
            acc = m_s1v && ((exp_q.size() < DEPTH) || pop);
            if (m_s1v && !acc && m_drop < 65535) m_drop++;
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(m_s1);
            m_s1v = nv;
            if (nv) m_s1 = ref_sample(int'(bus.node_in));
            case (m_mode)
                0: begin
                    m_cnt = 0;
                    if (strike_req) m_mode = 2;
                    else if (strike_en) m_mode = 1;
                end
                1: begin
                    if (strike_req) begin m_mode = 2; m_cnt = 0; end
                    else if (nv && m_cnt + 1 == PERIOD) begin m_mode = 2; m_cnt = 0; end
                    else if (!strike_en) begin m_mode = 0; m_cnt = 0; end
                    else if (nv) m_cnt++;
                end
                2: m_mode = 3;
                default: begin
                    if (nv) begin
                        m_mode = strike_en ? 1 : 0;
                        m_cnt  = strike_en ? 1 : 0;
                    end
                end
            endcase
            m_shoot = (m_mode == 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        bus.node_in    = 18'(v);
        bus.node_valid = 1'b1;
        step();
        bus.node_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        vectors++; if (bus.audio_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b exp=0", bus.audio_valid); end
        vectors++; if (bus.audio_data !== 16'sh0000) begin miscompares++; $display("FAIL reset_data got=%h exp=0000", bus.audio_data); end
        vectors++; if (shoot !== 1'b0) begin miscompares++; $display("FAIL reset_shoot got=%0b exp=0", shoot); end
        vectors++; if (drop_count !== 16'h0000) begin miscompares++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        rst = 1'b1;
        step();
        vectors++; if (bus.audio_data !== 16'sh0000) begin miscompares++; $display("FAIL reset_data_after got=%h exp=0000", bus.audio_data); end
    endtask

    task automatic test_gain();
        int          vin [4] = '{32'sh04000, 32'sh08000, -32'sh20000, -32'sh01000};
        logic [15:0] vexp[4] = '{16'h4000, 16'h7FFF, 16'h8000, 16'hF000};
        bus.audio_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse(vin[i]);
            vectors++; if (bus.audio_valid !== 1'b0) begin miscompares++; $display("FAIL gain_latency_early[%0d] got=%0b exp=0", i, bus.audio_valid); end
            step();
            vectors++; if (bus.audio_valid !== 1'b1) begin miscompares++; $display("FAIL gain_latency[%0d] got=%0b exp=1", i, bus.audio_valid); end
            vectors++; if (bus.audio_data !== vexp[i]) begin miscompares++; $display("FAIL gain_data[%0d] got=%h exp=%h", i, bus.audio_data, vexp[i]); end
            step();
            vectors++; if (bus.audio_valid !== 1'b0) begin miscompares++; $display("FAIL gain_drain[%0d] got=%0b exp=0", i, bus.audio_valid); end
        end
    endtask

    task automatic test_overflow();
        int vals[10];
        bus.audio_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vals[i] = int'($urandom_range(0, 262143)) - 131072;
            pulse(vals[i]);
            step(); step();
        end
        vectors++; if (drop_count !== 16'd2) begin miscompares++; $display("FAIL overflow_drop got=%0d exp=2", drop_count); end
        vectors++; if (bus.audio_data !== ref_sample(vals[0])) begin miscompares++; $display("FAIL overflow_hold got=%h exp=%h", bus.audio_data, ref_sample(vals[0])); end
        step();
        vectors++; if (bus.audio_data !== ref_sample(vals[0])) begin miscompares++; $display("FAIL overflow_stable got=%h exp=%h", bus.audio_data, ref_sample(vals[0])); end
        bus.audio_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++; if (bus.audio_valid !== 1'b1 || bus.audio_data !== ref_sample(vals[i])) begin
                miscompares++; $display("FAIL overflow_beat[%0d] got=%0b/%h exp=1/%h", i, bus.audio_valid, bus.audio_data, ref_sample(vals[i]));
            end
            step();
        end
        vectors++; if (bus.audio_valid !== 1'b0) begin miscompares++; $display("FAIL overflow_empty got=%0b exp=0", bus.audio_valid); end
    endtask

    task automatic test_full_pop();
        int vals[9];
        logic [15:0] d0;
        bus.audio_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vals[i] = int'($urandom_range(0, 262143)) - 131072;
            pulse(vals[i]);
        end
        d0 = drop_count;
        bus.audio_ready = 1'b1;
        step();
        vectors++; if (drop_count !== d0) begin miscompares++; $display("FAIL fullpop_drop got=%0d exp=%0d", drop_count, d0); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (bus.audio_valid !== 1'b1 || bus.audio_data !== ref_sample(vals[i+1])) begin
                miscompares++; $display("FAIL fullpop_beat[%0d] got=%0b/%h exp=1/%h", i, bus.audio_valid, bus.audio_data, ref_sample(vals[i+1]));
            end
            step();
        end
        vectors++; if (bus.audio_valid !== 1'b0) begin miscompares++; $display("FAIL fullpop_empty got=%0b exp=0", bus.audio_valid); end
    endtask

    task automatic test_strike();
        bit want;
        strike_en = 1'b1;
        step();
        for (int p = 1; p <= 9; p++) begin
            pulse(p);
            want = (p == 4) || (p == 8);
            vectors++; if (shoot !== want || shoot !== m_shoot) begin miscompares++; $display("FAIL strike_pulse[%0d] got=%0b exp=%0b", p, shoot, want); end
            step();
            vectors++; if (shoot !== 1'b0) begin miscompares++; $display("FAIL strike_width[%0d] got=%0b exp=0", p, shoot); end
            if (p == 4) begin
                strike_req = 1'b1; step(); strike_req = 1'b0;
                vectors++; if (shoot !== 1'b0) begin miscompares++; $display("FAIL strike_hold_req got=%0b exp=0", shoot); end
            end
            step();
        end
        strike_en = 1'b0;
        step();
        strike_req = 1'b1; step(); strike_req = 1'b0;
        vectors++; if (shoot !== 1'b1) begin miscompares++; $display("FAIL strike_manual got=%0b exp=1", shoot); end
        step();
        vectors++; if (shoot !== 1'b0) begin miscompares++; $display("FAIL strike_manual_width got=%0b exp=0", shoot); end
        pulse(0);
        step(); step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            bus.node_valid  = ($urandom_range(0, 2) == 0);
            bus.node_in     = 18'($urandom);
            bus.audio_ready = (c < 750) ? ($urandom_range(0, 7) < 2) : ($urandom_range(0, 7) < 6);
            strike_req      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) strike_en = ~strike_en;
            step();
            vectors++; if (bus.audio_valid !== (exp_q.size() > 0)) begin miscompares++; $display("FAIL rand_valid@%0d got=%0b exp=%0b", c, bus.audio_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                vectors++; if (bus.audio_data !== exp_q[0]) begin miscompares++; $display("FAIL rand_data@%0d got=%h exp=%h", c, bus.audio_data, exp_q[0]); end
            end
            vectors++; if (drop_count !== 16'(m_drop)) begin miscompares++; $display("FAIL rand_drop@%0d got=%0d exp=%0d", c, drop_count, m_drop); end
            vectors++; if (shoot !== m_shoot) begin miscompares++; $display("FAIL rand_shoot@%0d got=%0b exp=%0b", c, shoot, m_shoot); end
        end
        bus.node_valid = 1'b0;
        strike_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        int shots;
        strike_en = 1'b0;
        bus.audio_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        bus.audio_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(int'($urandom_range(0, 262143)) - 131072);
        step();
        bus.audio_ready = 1'b1;
        strike_req = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        strike_req = 1'b0;
        vectors++; if (bus.audio_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got=%0b exp=0", bus.audio_valid); end
        vectors++; if (drop_count !== 16'h0000) begin miscompares++; $display("FAIL midrst_drop got=%0d exp=0", drop_count); end
        vectors++; if (shoot !== 1'b0) begin miscompares++; $display("FAIL midrst_shoot got=%0b exp=0", shoot); end
        step();
        vectors++; if (shoot !== 1'b0 || bus.audio_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_pending got=%0b/%0b exp=0/0", shoot, bus.audio_valid); end
        strike_en = 1'b1;
        step();
        shots = 0;
        for (int p = 1; p <= 4; p++) begin
            pulse(p);
            if (shoot === 1'b1) shots++;
            vectors++; if (shoot !== m_shoot) begin miscompares++; $display("FAIL midrst_fsm[%0d] got=%0b exp=%0b", p, shoot, m_shoot); end
            step();
        end
        vectors++; if (shots != 1) begin miscompares++; $display("FAIL midrst_idle_period got=%0d exp=1", shots); end
    endtask

    initial begin
        rst = 1'b0;
        strike_en = 1'b0;
        strike_req = 1'b0;
        bus.node_in = 18'sh00000;
        bus.node_valid = 1'b0;
        bus.audio_ready = 1'b1;
        test_reset();
        test_gain();
        test_overflow();
        test_full_pop();
        test_strike();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
